// File: rtl/seg_scan.sv
// seg_scan: multiplexed 8-digit 7-segment scanner with frame-synchronous input shadows,
// per-digit enable/blink and anode dead-time; feeds the hex-to-segment decoder.
module seg_scan #(
   parameter int CLK_FREQ     = 100000000,
   parameter int SCAN_HZ      = 1000,
   parameter int DIGITS       = 8,
   parameter int DEAD_CYCLES  = 16,
   parameter int BLINK_FRAMES = 250
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   digits_in,
   input  logic [DIGITS-1:0]     digit_en,
   input  logic [DIGITS-1:0]     blink_en,
   input  logic [DIGITS-1:0]     dp_in,
   output logic [3:0]            num_out,
   output logic                  dp_n_out,
   output logic [DIGITS-1:0]     an_out,
   output logic                  frame_start
);
   localparam int DIV = CLK_FREQ / (SCAN_HZ * DIGITS);
   localparam int PW  = DIV > 1 ? $clog2(DIV) : 1;
   localparam int IW  = $clog2(DIGITS);
   localparam int BW  = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PW-1:0] P_MAX = PW'(DIV - 1);
   localparam logic [PW-1:0] DEAD  = PW'(DEAD_CYCLES);
   localparam logic [IW-1:0] I_MAX = IW'(DIGITS - 1);
   localparam logic [BW-1:0] B_MAX = BW'(BLINK_FRAMES - 1);

   logic [PW-1:0]         p_q, p_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [BW-1:0]         bcnt_q, bcnt_d;
   logic                  phase_q, phase_d;
   logic                  prime_q, prime_d;
   logic [4*DIGITS-1:0]   dig_q, dig_d;
   logic [DIGITS-1:0]     en_q, en_d, bl_q, bl_d, dp_q, dp_d;
   logic [3:0]            num_q, num_d;
   logic                  dp_n_q, dp_n_d;
   logic [DIGITS-1:0]     an_q, an_d;
   logic                  fs_q, fs_d;
   logic                  slot_end, wrap, load, lit;

   // Outputs are computed from next-state values so they line up with the slot they describe.
   // prime_q loads the shadows on the first cycle after reset so the post-reset frame is not blank.
   always_comb begin
      slot_end = p_q == P_MAX;
      wrap     = slot_end && idx_q == I_MAX;
      load     = wrap || prime_q;
      prime_d  = 1'b0;
      p_d      = slot_end ? '0 : p_q + PW'(1);
      idx_d    = slot_end ? (wrap ? '0 : idx_q + IW'(1)) : idx_q;
      bcnt_d   = wrap ? (bcnt_q == B_MAX ? '0 : bcnt_q + BW'(1)) : bcnt_q;
      phase_d  = phase_q ^ (wrap && bcnt_q == B_MAX);
      dig_d    = load ? digits_in : dig_q;
      en_d     = load ? digit_en : en_q;
      bl_d     = load ? blink_en : bl_q;
      dp_d     = load ? dp_in : dp_q;
      lit      = p_d >= DEAD && en_d[idx_d] && !(bl_d[idx_d] && phase_d);
      an_d     = lit ? ~(DIGITS'(1) << idx_d) : '1;
      num_d    = dig_d[{idx_d, 2'b00} +: 4];
      dp_n_d   = !(lit && dp_d[idx_d]);
      fs_d     = wrap;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q     <= '0;
         idx_q   <= '0;
         bcnt_q  <= '0;
         phase_q <= 1'b0;
         prime_q <= 1'b1;
         dig_q   <= '0;
         en_q    <= '0;
         bl_q    <= '0;
         dp_q    <= '0;
         num_q   <= '0;
         dp_n_q  <= 1'b1;
         an_q    <= '1;
         fs_q    <= 1'b0;
      end else begin
         p_q     <= p_d;
         idx_q   <= idx_d;
         bcnt_q  <= bcnt_d;
         phase_q <= phase_d;
         prime_q <= prime_d;
         dig_q   <= dig_d;
         en_q    <= en_d;
         bl_q    <= bl_d;
         dp_q    <= dp_d;
         num_q   <= num_d;
         dp_n_q  <= dp_n_d;
         an_q    <= an_d;
         fs_q    <= fs_d;
      end
   end

   assign num_out     = num_q;
   assign dp_n_out    = dp_n_q;
   assign an_out      = an_q;
   assign frame_start = fs_q;
endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Time-multiplexed scanner for the 8-digit common-anode 7-segment display. Sits directly upstream of the hex-to-segment decoder.
- Each scan slot it selects one digit's 4-bit value, drives it on num_out to the decoder, and drives one active-low anode line.
- It also drives a separate active-low decimal-point line.
- Adds frame-synchronous input latching, per-digit enable, per-digit blink, and anode dead-time to suppress ghosting.

Parameters:
- CLK_FREQ, 100000000, input clock frequency in Hz.
- SCAN_HZ, 1000, full-frame refresh rate in Hz. Slot length DIV = CLK_FREQ/(SCAN_HZ*DIGITS) cycles; DIV must be >= DEAD_CYCLES+2.
- DIGITS, 8, number of digits scanned (2..8).
- DEAD_CYCLES, 16, cycles at the start of each slot during which all anodes are off.
- BLINK_FRAMES, 250, frames per blink half-period.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- digits_in  in  4*DIGITS  digit values; digit i = bits [4i+3:4i]; digit 0 is rightmost
- digit_en  in  DIGITS  1 = digit i displayed, 0 = anode i held off
- blink_en  in  DIGITS  1 = digit i blanked during the blink-off phase
- dp_in  in  DIGITS  1 = decimal point of digit i lit
- num_out  out  4  current digit value, to the segment decoder
- dp_n_out  out  1  active-low decimal point for the current digit
- an_out  out  DIGITS  active-low anode selects, at most one low at any time
- frame_start  out  1  one-cycle pulse when slot 0 begins

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. All state and outputs are registered.
- Reset values:
  - prescaler = 0, slot index idx = 0, blink counter = 0, blink phase = 0 (on)
  - shadow registers = 0
  - num_out = 0, dp_n_out = 1, an_out = all 1s, frame_start = 0
- Prescaler: counts 0..DIV-1 and wraps. A slot boundary occurs on the cycle the count equals DIV-1.
- Slot index at a slot boundary:
  - idx advances by 1; at DIGITS-1 it wraps to 0.
  - When wrapping to 0: frame_start pulses for 1 cycle in the first cycle of slot 0.
  - Same boundary: digits_in, digit_en, blink_en and dp_in are copied into shadow registers.
  - Mid-frame input changes therefore appear only from the next frame; no tearing.
- Output timing within a slot (prescaler value p):
  - num_out and dp_n_out = shadow value of digit idx, updated on the first cycle of the slot.
  - p < DEAD_CYCLES: an_out = all 1s.
  - p >= DEAD_CYCLES: an_out[idx] = 0 only if digit_en[idx] && !(blink_en[idx] && blink_phase); all other bits = 1.
  - dp_n_out = ~dp_in[idx] (shadow), forced to 1 while the anode is off.
- Blink: the blink counter increments at each frame wrap. When it reaches BLINK_FRAMES-1 it clears and blink_phase toggles. Phase 1 = blanked.
- Asynchronous reset mid-frame: all outputs return to reset values immediately. Scanning restarts at slot 0 with a dead-time period first. frame_start does not pulse for the post-reset slot 0.
- Invariant: an_out never has more than one bit low, including on the cycle of any transition.

Test Plan:
Test parameters: CLK_FREQ=800, SCAN_HZ=10, DIGITS=8, DEAD_CYCLES=2, BLINK_FRAMES=2, giving DIV=10.
- Reset release, digits_in=32'h76543210, all enables 1, dp_in=0 -> an_out=8'hFF for cycles 0-1; an_out=8'hFE, num_out=0 for cycles 2-9; cycle 10 num_out=1, an_out=FF; cycles 12-19 an_out=8'hFD; pattern repeats after 80 cycles with one frame_start pulse per frame.
- digits_in changed from 32'h76543210 to 32'h89ABCDEF during slot 3 -> slots 3..7 still show 3..7; next frame shows F,E,D,...; num_out never shows a mix within a frame.
- digit_en=8'b1111_0000 -> an_out stays FF during slots 0-3; normal single-low pattern in slots 4-7.
- blink_en=8'h01 -> digit 0 is lit in frames 0-1, blank (an_out FF throughout slot 0) in frames 2-3, lit again in frames 4-5; other digits unaffected.
- dp_in=8'h04 -> dp_n_out=0 only during lit cycles (prescaler value >= 2) of slot 2; 1 everywhere else, including slot-2 dead time.
- rst_n pulsed low in the middle of slot 5 -> an_out=FF, num_out=0, dp_n_out=1 within the same cycle; after release, slot 0 resumes with 2 dead cycles; a checker confirms at most one low an_out bit on every cycle across all tests.
